// File: rtl/reg_pkg.sv
// CPU-wide register/status types shared with the control unit.
package reg_pkg;

    typedef enum logic [1:0] {
        USER       = 2'd0,
        SUPERVISOR = 2'd1
    } cpu_mode_e;

endpackage

// File: rtl/trap_pkg.sv
// Trap sequencer types, cause encoding and vector computation.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PUSH   = 2'd1,
        VECTOR = 2'd2,
        FAULT  = 2'd3
    } trap_state_e;

    localparam logic [5:0] CAUSE_SWINT   = 6'd2;
    localparam logic [5:0] CAUSE_EXCEPT  = 6'd3;
    localparam logic [5:0] CAUSE_HW_BASE = 6'd4;

    // Callers truncate the result to their PC width, giving modulo-2^ADDR_W wrap.
    function automatic logic [63:0] vector_of(input logic [63:0] base, input logic [5:0] cause);
        return base + {58'd0, cause};
    endfunction

endpackage

// File: rtl/trap_ctl_if.sv
// Request/control bundle between the control unit side and trap_ctl.
interface trap_ctl_if #(
    parameter int NUM_IRQ = 8,
    parameter int ADDR_W  = 32
);
    import reg_pkg::*;

    logic               en;
    logic [NUM_IRQ-1:0] irq;
    logic [NUM_IRQ-1:0] ien_in;
    logic               ld_ien;
    logic               imask;
    logic               boundary;
    logic               swint_req;
    logic               except_req;
    logic               mem_ready;

    logic               trap_active;
    logic               pre_dec_sp;
    logic               push_pc;
    logic               wr;
    logic [ADDR_W-1:0]  vec_addr;
    logic               ld_pc;
    logic               ld_imask;
    logic               imask_in;
    logic               ld_mode;
    cpu_mode_e          mode_in;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [5:0]         cause;
    logic               fault;

    modport master (
        output en, irq, ien_in, ld_ien, imask, boundary, swint_req, except_req, mem_ready,
        input  trap_active, pre_dec_sp, push_pc, wr, vec_addr, ld_pc, ld_imask, imask_in,
               ld_mode, mode_in, irq_ack, cause, fault
    );

    modport slave (
        input  en, irq, ien_in, ld_ien, imask, boundary, swint_req, except_req, mem_ready,
        output trap_active, pre_dec_sp, push_pc, wr, vec_addr, ld_pc, ld_imask, imask_in,
               ld_mode, mode_in, irq_ack, cause, fault
    );

endinterface

// File: rtl/trap_irq_pend.sv
// Hardware interrupt capture (edge/level), enable register and lowest-index priority pick.
module trap_irq_pend #(
    parameter int                 NUM_IRQ  = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] ien_in,
    input  logic               ld_ien,
    input  logic               imask,
    input  logic [NUM_IRQ-1:0] ack,
    output logic               hw_valid,
    output logic [4:0]         hw_idx
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] edge_lat;
    logic [NUM_IRQ-1:0] ien;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] takeable;

    // A new edge arriving with the ack re-arms the latch (set wins over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q    <= '0;
            edge_lat <= '0;
            ien      <= '0;
        end else begin
            irq_q    <= irq;
            edge_lat <= ((edge_lat & ~ack) | (irq & ~irq_q)) & IRQ_EDGE;
            if (ld_ien) ien <= ien_in;
        end
    end

    assign pend     = edge_lat | (irq & ~IRQ_EDGE);
    assign takeable = pend & ien & {NUM_IRQ{imask}};

    always_comb begin
        hw_valid = 1'b0;
        hw_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (takeable[i]) begin
                hw_valid = 1'b1;
                hw_idx   = 5'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctl.sv
// Trap-entry sequencer: picks the highest-priority cause at an instruction boundary,
// pushes PC with wait-state tolerance, then loads the vector, mode and imask.
//
//   state  | meaning
//   IDLE   | waiting for a boundary with a takeable cause
//   PUSH   | PC write to stack, waiting on mem_ready
//   VECTOR | one cycle of PC/mode/imask loads and ack
//   FAULT  | push timed out; held until reset
module trap_ctl
    import reg_pkg::*;
    import trap_pkg::*;
#(
    parameter int                 NUM_IRQ  = 8,
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  VEC_BASE = '0,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter int                 MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    trap_ctl_if.slave  bus
);

    trap_state_e state;
    logic [5:0]  cause_q;
    logic [7:0]  wait_cnt;
    logic        swint_flag;
    logic        except_flag;
    logic        hw_valid;
    logic [4:0]  hw_idx;
    logic        in_vec;
    logic        is_hw;
    logic [5:0]  hw_sel;
    logic        clr_swint;
    logic        clr_except;

    trap_irq_pend #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .irq      (bus.irq),
        .ien_in   (bus.ien_in),
        .ld_ien   (bus.ld_ien),
        .imask    (bus.imask),
        .ack      (bus.irq_ack & {NUM_IRQ{bus.en}}),
        .hw_valid (hw_valid),
        .hw_idx   (hw_idx)
    );

    assign in_vec     = (state == VECTOR);
    assign is_hw      = (cause_q >= CAUSE_HW_BASE);
    assign hw_sel     = cause_q - CAUSE_HW_BASE;
    assign clr_swint  = bus.en && in_vec && (cause_q == CAUSE_SWINT);
    assign clr_except = bus.en && in_vec && (cause_q == CAUSE_EXCEPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cause_q     <= '0;
            wait_cnt    <= '0;
            swint_flag  <= 1'b0;
            except_flag <= 1'b0;
        end else begin
            swint_flag  <= bus.swint_req  | (swint_flag  & ~clr_swint);
            except_flag <= bus.except_req | (except_flag & ~clr_except);
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        if (bus.boundary && (except_flag || swint_flag || hw_valid)) begin
                            if (except_flag)     cause_q <= CAUSE_EXCEPT;
                            else if (swint_flag) cause_q <= CAUSE_SWINT;
                            else                 cause_q <= CAUSE_HW_BASE + {1'b0, hw_idx};
                            wait_cnt <= '0;
                            state    <= PUSH;
                        end
                    end
                    PUSH: begin
                        if (bus.mem_ready) begin
                            state <= VECTOR;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (wait_cnt + 8'd1 == 8'(MAX_WAIT)) state <= FAULT;
                        end
                    end
                    VECTOR:  state <= IDLE;
                    default: state <= FAULT;
                endcase
            end
        end
    end

    // wait_cnt is still zero only in the first PUSH cycle, so SP drops once.
    assign bus.trap_active = (state != IDLE);
    assign bus.push_pc     = (state == PUSH);
    assign bus.wr          = (state == PUSH);
    assign bus.pre_dec_sp  = (state == PUSH) && (wait_cnt == 8'd0);
    assign bus.vec_addr    = in_vec ? ADDR_W'(vector_of(64'(VEC_BASE), cause_q)) : '0;
    assign bus.ld_pc       = in_vec;
    assign bus.ld_mode     = in_vec;
    assign bus.mode_in     = in_vec ? SUPERVISOR : USER;
    assign bus.ld_imask    = in_vec && is_hw;
    assign bus.imask_in    = 1'b0;
    assign bus.irq_ack     = (in_vec && is_hw) ? (NUM_IRQ'(1) << hw_sel) : '0;
    assign bus.cause       = cause_q;
    assign bus.fault       = (state == FAULT);

endmodule
